// File: rtl/aes_gcm_pkg.sv
// Shared types and constants for the GCM datapath: block width, AES pipeline
// depth and the requester tag carried alongside each in-flight block.
package aes_gcm_pkg;
  localparam int BLOCK_W = 128;
  localparam int AES_LAT = 12;

  typedef logic [0:0] req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
  } tag_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with credit masking. The requester served last
// yields to the other one when both are valid and eligible.
module rr_arb2
  import aes_gcm_pkg::*;
(
  input  logic [1:0] valid,
  input  logic [1:0] elig,
  input  req_id_t    last,
  output logic [1:0] grant
);

  logic [1:0] cand;

  assign cand     = valid & elig;
  assign grant[0] = cand[0] & ~(cand[1] & (last == 1'b0));
  assign grant[1] = cand[1] & ~(cand[0] & (last == 1'b1));

endmodule

// File: rtl/aes_pipe_arbiter.sv
// Shares one pipelined AES unit between two requesters: round-robin issue,
// tag tracking across the fixed AES latency, result routing and credit limits.
module aes_pipe_arbiter
  import aes_gcm_pkg::*;
#(
  parameter int LAT          = AES_LAT,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] req0_data,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [BLOCK_W-1:0] req1_data,
  input  logic               req1_valid,
  output logic               req1_ready,
  output logic [BLOCK_W-1:0] aes_in,
  output logic               aes_vin,
  input  logic [BLOCK_W-1:0] aes_out,
  input  logic               aes_vout,
  output logic [BLOCK_W-1:0] rsp0_data,
  output logic               rsp0_valid,
  output logic [BLOCK_W-1:0] rsp1_data,
  output logic               rsp1_valid,
  output logic [7:0]         inflight0,
  output logic [7:0]         inflight1,
  output logic               err
);

  // Handshake: a block transfers on an edge where valid and ready are both
  // high. Ready never looks at its own valid, only at credit and at the other
  // requester's valid, so a source may hold valid and wait without a loop.
  // Responses have no backpressure: rsp*_valid is a one-cycle strobe.

  req_id_t    last;
  logic [1:0] elig;
  logic [1:0] grant;
  logic [1:0] inc;
  logic [1:0] dec;
  logic [7:0] inflight0_nxt;
  logic [7:0] inflight1_nxt;
  tag_t       tag_q [LAT];
  tag_t       head;

  assign elig[0] = inflight0 < 8'(MAX_INFLIGHT);
  assign elig[1] = inflight1 < 8'(MAX_INFLIGHT);

  rr_arb2 u_arb (
    .valid (({req1_valid, req0_valid})),
    .elig  (elig),
    .last  (last),
    .grant (grant)
  );

  assign req0_ready = elig[0] & ~(req1_valid & elig[1] & (last == 1'b0));
  assign req1_ready = elig[1] & ~(req0_valid & elig[0] & (last == 1'b1));

  // The head is the tag issued LAT edges ago, aligned with aes_vout.
  assign head = tag_q[LAT-1];

  always_comb begin
    inc           = grant;
    dec[0]        = head.vld & (head.id == 1'b0);
    dec[1]        = head.vld & (head.id == 1'b1);
    inflight0_nxt = inflight0 + 8'(inc[0]) - 8'(dec[0]);
    inflight1_nxt = inflight1 + 8'(inc[1]) - 8'(dec[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aes_in     <= '0;
      aes_vin    <= 1'b0;
      last       <= 1'b1;
      rsp0_data  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_valid <= 1'b0;
      inflight0  <= '0;
      inflight1  <= '0;
      err        <= 1'b0;
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      aes_vin <= |grant;
      if (grant[0]) begin
        aes_in <= req0_data;
        last   <= 1'b0;
      end else if (grant[1]) begin
        aes_in <= req1_data;
        last   <= 1'b1;
      end

      tag_q[0] <= '{vld: |grant, id: grant[1]};
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];

      rsp0_valid <= head.vld & aes_vout & (head.id == 1'b0);
      rsp1_valid <= head.vld & aes_vout & (head.id == 1'b1);
      if (head.vld & aes_vout & (head.id == 1'b0)) rsp0_data <= aes_out;
      if (head.vld & aes_vout & (head.id == 1'b1)) rsp1_data <= aes_out;

      // A mismatch drops the response but still retires the credit.
      if (head.vld != aes_vout) err <= 1'b1;

      inflight0 <= inflight0_nxt;
      inflight1 <= inflight1_nxt;
    end
  end

endmodule

// File: tb/tb_aes_pipe_arbiter.sv
// Bench for aes_pipe_arbiter: an 11-stage AES stand-in returning ~data, a
// queue-based reference of outstanding blocks, a grant table and corner cases.
module tb_aes_pipe_arbiter;
  import aes_gcm_pkg::*;

  localparam int W    = 128;
  localparam int LAT  = 12;
  localparam int MAXF = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] aes_in, aes_out;
  logic         aes_vin, aes_vout;
  logic [W-1:0] rsp0_data, rsp1_data;
  logic         rsp0_valid, rsp1_valid;
  logic [7:0]   inflight0, inflight1;
  logic         err;

  aes_pipe_arbiter #(.LAT(LAT), .MAX_INFLIGHT(MAXF)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .aes_in     (aes_in),
    .aes_vin    (aes_vin),
    .aes_out    (aes_out),
    .aes_vout   (aes_vout),
    .rsp0_data  (rsp0_data),
    .rsp0_valid (rsp0_valid),
    .rsp1_data  (rsp1_data),
    .rsp1_valid (rsp1_valid),
    .inflight0  (inflight0),
    .inflight1  (inflight1),
    .err        (err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AES stand-in: 11 stages, returns ~data ----------------
  logic         drop_en;
  logic [W-1:0] drop_data;
  logic [W-1:0] pd [11];
  logic         pv [11];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 11; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= aes_vin && !(drop_en && aes_in == drop_data);
      pd[0] <= ~aes_in;
      for (int i = 1; i < 11; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign aes_vout = pv[10];
  assign aes_out  = pd[10];

  // ---------------- reference model: outstanding blocks ----------------
  typedef struct {
    logic         id;
    logic [W-1:0] data;
    int           due;
    logic         drop;
  } ent_t;

  ent_t         exp_q[$];
  int           ecount;
  logic         m_last, m_err, m_vin, m_rsp0_v, m_rsp1_v;
  logic [W-1:0] m_aes_in, m_rsp0_data, m_rsp1_data;

  int   errors, checks;
  int   n_rsp0, n_rsp1, n_acc1;
  logic obs_r0, obs_r1;

  function automatic int count_id(logic id);
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].id == id) n++;
    return n;
  endfunction

  function automatic logic [W-1:0] rnd_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%h expected=%h", name, ecount, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic v1);
    req0_valid = v0;
    req1_valid = v1;
    req0_data  = rnd_blk();
    req1_data  = rnd_blk();
  endtask

  // One clock: check readies before the edge, advance the model, check outputs after.
  task automatic step();
    logic e0, e1, r0, r1, a0, a1;
    logic [W-1:0] d0, d1;
    ent_t ent;
    @(negedge clk);
    e0 = count_id(1'b0) < MAXF;
    e1 = count_id(1'b1) < MAXF;
    r0 = e0 & ~(req1_valid & e1 & (m_last == 1'b0));
    r1 = e1 & ~(req0_valid & e0 & (m_last == 1'b1));
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    if (!rst) begin
      check("req0_ready", {127'd0, req0_ready}, {127'd0, r0});
      check("req1_ready", {127'd0, req1_ready}, {127'd0, r1});
      if (req1_valid && req1_ready) n_acc1++;
    end
    a0 = !rst && req0_valid && r0;
    a1 = !rst && req1_valid && r1;
    d0 = req0_data;
    d1 = req1_data;
    @(posedge clk);
    #1;
    ecount++;
    if (rst) begin
      exp_q.delete();
      m_last = 1'b1; m_err = 1'b0; m_vin = 1'b0; m_aes_in = '0;
      m_rsp0_v = 1'b0; m_rsp1_v = 1'b0; m_rsp0_data = '0; m_rsp1_data = '0;
    end else begin
      m_rsp0_v = 1'b0;
      m_rsp1_v = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == ecount) begin
        ent = exp_q.pop_front();
        if (ent.drop) m_err = 1'b1;
        else if (ent.id == 1'b0) begin m_rsp0_v = 1'b1; m_rsp0_data = ~ent.data; end
        else begin m_rsp1_v = 1'b1; m_rsp1_data = ~ent.data; end
      end
      m_vin = a0 | a1;
      if (a0 || a1) begin
        ent.id   = a1;
        ent.data = a1 ? d1 : d0;
        ent.due  = ecount + LAT;
        ent.drop = drop_en && (ent.data == drop_data);
        exp_q.push_back(ent);
        m_aes_in = ent.data;
        m_last   = a1;
      end
    end
    check("aes_vin", {127'd0, aes_vin}, {127'd0, m_vin});
    check("aes_in", aes_in, m_aes_in);
    check("rsp0_valid", {127'd0, rsp0_valid}, {127'd0, m_rsp0_v});
    check("rsp1_valid", {127'd0, rsp1_valid}, {127'd0, m_rsp1_v});
    check("rsp0_data", rsp0_data, m_rsp0_data);
    check("rsp1_data", rsp1_data, m_rsp1_data);
    check("inflight0", {120'd0, inflight0}, W'(count_id(1'b0)));
    check("inflight1", {120'd0, inflight1}, W'(count_id(1'b1)));
    check("err", {127'd0, err}, {127'd0, m_err});
    if (rsp0_valid === 1'b1) n_rsp0++;
    if (rsp1_valid === 1'b1) n_rsp1++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0);
      step();
    end
  endtask

  // ---------------- grant table, applied straight after reset ----------------
  typedef struct {
    logic v0, v1, r0, r1;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int s0, s1, lows, tries;
    errors = 0; checks = 0; ecount = 0;
    n_rsp0 = 0; n_rsp1 = 0; n_acc1 = 0;
    drop_en = 1'b0; drop_data = '0;
    m_last = 1'b1; m_err = 1'b0; m_vin = 1'b0; m_aes_in = '0;
    m_rsp0_v = 1'b0; m_rsp1_v = 1'b0; m_rsp0_data = '0; m_rsp1_data = '0;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0};

    // reset state
    rst = 1'b1;
    drive(1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;

    // round-robin table
    foreach (tbl[i]) begin
      drive(tbl[i].v0, tbl[i].v1);
      step();
      check("tbl_ready0", {127'd0, obs_r0}, {127'd0, tbl[i].r0});
      check("tbl_ready1", {127'd0, obs_r1}, {127'd0, tbl[i].r1});
    end
    idle(LAT + 2);

    // lone requester 0: three blocks
    s0 = n_rsp0; s1 = n_rsp1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      step();
    end
    idle(LAT + 3);
    check("lone0_rsp0_count", W'(n_rsp0 - s0), W'(3));
    check("lone0_rsp1_count", W'(n_rsp1 - s1), W'(0));

    // ten cycles of contention
    s0 = n_rsp0; s1 = n_rsp1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1);
      step();
    end
    idle(LAT + 3);
    check("contend_rsp0_count", W'(n_rsp0 - s0), W'(5));
    check("contend_rsp1_count", W'(n_rsp1 - s1), W'(5));

    // requester 1 streaming alone: credit stall then one accept per return
    n_acc1 = 0; lows = 0;
    for (int i = 0; i < LAT + 1; i++) begin
      drive(1'b0, 1'b1);
      step();
      if (!obs_r1) lows++;
    end
    check("stream1_accepts", W'(n_acc1), W'(8));
    check("stream1_stall_cycles", W'(lows), W'(5));
    drive(1'b0, 1'b1);
    step();
    check("stream1_resume", {127'd0, obs_r1}, {127'd0, 1'b1});
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1);
      step();
    end
    idle(LAT + 3);

    // tag/valid mismatch: the second of three blocks loses its aes_vout
    drop_en = 1'b1;
    drop_data = 128'h5a5a_0000_1111_2222_3333_4444_5555_a5a5;
    s0 = n_rsp0;
    drive(1'b1, 1'b0); step();
    drive(1'b1, 1'b0); req0_data = drop_data; step();
    drive(1'b1, 1'b0); step();
    idle(LAT + 3);
    check("mismatch_err", {127'd0, err}, {127'd0, 1'b1});
    check("mismatch_inflight0", {120'd0, inflight0}, W'(0));
    check("mismatch_rsp0_count", W'(n_rsp0 - s0), W'(2));
    drop_en = 1'b0;

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      step();
    end
    idle(LAT + 3);

    // mid-burst reset with at least five blocks in flight
    tries = 0;
    while (exp_q.size() < 5 && tries < 20) begin
      drive(1'b1, 1'b1);
      step();
      tries++;
    end
    check("prereset_inflight", W'(exp_q.size() >= 5), W'(1));
    rst = 1'b1;
    drive(1'b0, 1'b0);
    step();
    rst = 1'b0;
    s0 = n_rsp0; s1 = n_rsp1;
    idle(LAT + 4);
    check("postreset_no_rsp", W'((n_rsp0 - s0) + (n_rsp1 - s1)), W'(0));
    drive(1'b1, 1'b1);
    step();
    check("postreset_grant0", {127'd0, obs_r0}, {127'd0, 1'b1});
    check("postreset_grant1", {127'd0, obs_r1}, {127'd0, 1'b0});
    idle(LAT + 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
